// File: rtl/bk_subtractor_pipe.sv
// Two-stage pipelined Brent-Kung subtractor: diff = a - b - bin, computed as a + ~b + !bin.
// Stage 1 resolves the low-half carries and high-half group P/G; stage 2 finishes the carries and registers the outputs.
module bk_subtractor_pipe #(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int HALF  = WIDTH / 2;
  localparam int LOG_H = $clog2(HALF);

  // Radix-2 Brent-Kung prefix over HALF (g, p) pairs; entry i covers bits 0..i.
  // Returns the group propagates when want_p is set, otherwise the group generates.
  function automatic logic [HALF-1:0] bk_scan(input logic [HALF-1:0] g_in,
                                              input logic [HALF-1:0] p_in,
                                              input logic            want_p);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    int              j;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LOG_H; l++) begin
      for (int i = 0; i < HALF; i++) begin
        if ((i % (2 << l)) == ((2 << l) - 1)) begin
          j    = (i >= (1 << l)) ? i - (1 << l) : 0;
          g[i] = g[i] | (p[i] & g[j]);
          p[i] = p[i] & p[j];
        end
      end
    end
    for (int l = LOG_H - 2; l >= 0; l--) begin
      for (int i = 0; i < HALF; i++) begin
        if ((i >= (3 * (1 << l)) - 1) && (((i + 1) % (2 << l)) == (1 << l))) begin
          j    = (i >= (1 << l)) ? i - (1 << l) : 0;
          g[i] = g[i] | (p[i] & g[j]);
          p[i] = p[i] & p[j];
        end
      end
    end
    return want_p ? p : g;
  endfunction

  logic s1_valid_q;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 combinational: bitwise P/G and the two half-width prefix trees.
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] p_w;
  logic [WIDTH-1:0] g_w;
  logic             c0;
  logic [HALF-1:0]  g_lo;
  logic [HALF-1:0]  c_lo_d;
  logic [HALF-1:0]  ggrp_d;
  logic [HALF-1:0]  pgrp_d;

  assign nb  = ~b;
  assign p_w = a ^ nb;
  assign g_w = a & nb;
  assign c0  = ~bin;

  always_comb begin
    // NOTE: every variable driven here gets a full default first so no latch is inferred.
    g_lo    = g_w[HALF-1:0];
    g_lo[0] = g_w[0] | (p_w[0] & c0);
    c_lo_d  = bk_scan(g_lo, p_w[HALF-1:0], 1'b0);
    ggrp_d  = bk_scan(g_w[WIDTH-1:HALF], p_w[WIDTH-1:HALF], 1'b0);
    pgrp_d  = bk_scan(g_w[WIDTH-1:HALF], p_w[WIDTH-1:HALF], 1'b1);
  end

  logic [HALF-1:0]  c_lo_q;
  logic [HALF-1:0]  ggrp_q;
  logic [HALF-1:0]  pgrp_q;
  logic [WIDTH-1:0] p_q;
  logic             c0_q;
  logic             a_msb_q;
  logic             nb_msb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: stage-1 datapath has no reset; s1_valid_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      c_lo_q   <= c_lo_d;
      ggrp_q   <= ggrp_d;
      pgrp_q   <= pgrp_d;
      p_q      <= p_w;
      c0_q     <= c0;
      a_msb_q  <= a[WIDTH-1];
      nb_msb_q <= nb[WIDTH-1];
    end
  end

  // Stage 2: carries[k] holds c[k+1]; high half folds in the midpoint carry c[HALF].
  logic [HALF-1:0]  c_hi;
  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] diff_raw;
  logic [WIDTH-1:0] diff_d;
  logic             ovf_d;

  assign c_hi     = ggrp_q | (pgrp_q & {HALF{c_lo_q[HALF-1]}});
  assign carries  = {c_hi, c_lo_q};
  assign diff_raw = p_q ^ {carries[WIDTH-2:0], c0_q};
  // Operand signs differ exactly when a's MSB equals the inverted subtrahend MSB.
  assign ovf_d    = (a_msb_q == nb_msb_q) & (diff_raw[WIDTH-1] != a_msb_q);

  always_comb begin
    diff_d = diff_raw;
    if (SAT_EN && ovf_d) begin
      diff_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        diff <= diff_d;
        bout <= ~carries[WIDTH-1];
        ovf  <= ovf_d;
        zero <= (diff_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Bench for bk_subtractor_pipe: wrap and saturating instances share stimulus and are checked
// every cycle against an arithmetic scoreboard, plus directed literal vectors.
module tb_bk_subtractor_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic         bout0, bout1, ovf0, ovf1, zero0, zero1;
  logic [W-1:0] diff0, diff1;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  bk_subtractor_pipe #(.WIDTH(W), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid0), .out_ready(out_ready),
    .diff(diff0), .bout(bout0), .ovf(ovf0), .zero(zero0)
  );

  bk_subtractor_pipe #(.WIDTH(W), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid1), .out_ready(out_ready),
    .diff(diff1), .bout(bout1), .ovf(ovf1), .zero(zero1)
  );

  typedef struct {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         bout;
    logic         ovf;
    logic         z0;
    logic         z1;
    int           acc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: unsigned borrow from a 33-bit difference, overflow from a wide signed one.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t        r;
    logic [W:0]  u;
    longint      s;
    u      = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    s      = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    r.d0   = u[W-1:0];
    r.bout = u[W];
    r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.d1   = !r.ovf ? u[W-1:0] : ((s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
    r.z0   = (r.d0 == '0);
    r.z1   = (r.d1 == '0);
    r.acc  = 0;
    return r;
  endfunction

  always @(negedge rst_n) q.delete();

  // Compare process: inputs are stable from posedge+1, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    bit   exp_ov;
    bit   exp_ir;
    exp_t e;
    if (rst_n) begin
      exp_ov = (q.size() > 0) && (cycle >= q[0].acc + 1);
      exp_ir = (q.size() < 2) || out_ready;
      check("in_ready", in_ready0, exp_ir);
      check("in_ready_sat", in_ready1, exp_ir);
      check("out_valid", out_valid0, exp_ov);
      check("out_valid_sat", out_valid1, exp_ov);
      if (exp_ov) begin
        check("diff", diff0, q[0].d0);
        check("diff_sat", diff1, q[0].d1);
        check("bout", {bout1, bout0}, {q[0].bout, q[0].bout});
        check("ovf", {ovf1, ovf0}, {q[0].ovf, q[0].ovf});
        check("zero", {zero1, zero0}, {q[0].z1, q[0].z0});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        e     = model(a, b, bin);
        e.acc = cycle + 1;
        q.push_back(e);
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One operation into an empty pipeline with out_ready high; checks latency and literal results.
  task automatic run_one(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, input logic [W-1:0] e_d0, input logic [W-1:0] e_d1,
                         input logic e_bout, input logic e_ovf, input logic e_zero);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid0 && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, 1);
    check({name, "_diff"}, diff0, e_d0);
    check({name, "_diff_sat"}, diff1, e_d1);
    check({name, "_bout"}, bout0, e_bout);
    check({name, "_ovf"}, {ovf1, ovf0}, {e_ovf, e_ovf});
    check({name, "_zero"}, zero0, e_zero);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  n;
    bit  took;

    #1 rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
    check("rst_diff", diff0, 0);
    check("rst_diff_sat", diff1, 0);
    check("rst_flags", {bout0, ovf0, zero0, bout1, ovf1, zero1}, 6'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_one("five_minus_three", 32'h5, 32'h3, 1'b0, 32'h2, 32'h2, 1'b0, 1'b0, 1'b0);
    run_one("zero_minus_one", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_one("a_minus_a_bin", 32'h1234, 32'h1234, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_one("a_minus_a", 32'h55, 32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    run_one("neg_ovf", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("pos_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("min_minus_bin", 32'h8000_0000, 32'h0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // Stall: two ops fill the pipe, a third waits at the input for five cycles.
    @(posedge clk); #1;
    out_ready = 1'b0; a = 32'd10; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd20; b = 32'd2;
    @(posedge clk); #1;
    a = 32'd30; b = 32'd3;
    check("stall_in_ready", in_ready0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_in_ready_hold", in_ready0, 1'b0);
      check("stall_valid_hold", out_valid0, 1'b1);
      check("stall_diff_hold", diff0, 32'd9);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("drain_first", {out_valid0, diff0}, {1'b1, 32'd18});
    @(posedge clk); #1;
    check("drain_second", {out_valid0, diff0}, {1'b1, 32'd27});
    @(posedge clk); #1;
    check("drain_done", out_valid0, 1'b0);

    // Random stream with input gaps and output backpressure; operands hold until accepted.
    sent = 0;
    for (int it = 0; it < 20000 && sent < 1000; it++) begin
      @(negedge clk);
      took = in_valid && in_ready0;
      @(posedge clk); #1;
      if (took) sent++;
      if (sent == 1000) begin
        in_valid = 1'b0;
      end else if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a        = pick();
        b        = pick();
        bin      = $urandom_range(0, 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 1000);
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stream_drained", q.size(), 0);

    // Reset with two ops in flight: outputs clear at once and the ops never emerge.
    @(posedge clk); #1;
    out_ready = 1'b0; a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd200; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {out_valid1, out_valid0}, 2'b00);
    check("async_rst_diff", {diff1, diff0}, 64'h0);
    check("async_rst_flags", {bout0, ovf0, zero0, bout1, ovf1, zero1}, 6'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", out_valid0, 1'b0);
    end
    run_one("post_rst", 32'h7, 32'h7, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
